// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider FSM states, operand width and the ALU
// operation codes EXE decodes into div_start/div_signed.
package cpu_defs;

  localparam int CPU_DATA_W = 32;
  localparam int DIV_ITERS  = CPU_DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } div_state_t;

  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

endpackage

// File: rtl/exe_div.sv
// Multi-cycle radix-2 restoring divider behind EXE for DIV/DIVU.
// Returns {remainder, quotient} with a ready handshake and holds the pipeline via stall_req.
module exe_div
  import cpu_defs::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     div_opdata1,
  input  logic [DATA_W-1:0]     div_opdata2,
  input  logic                  div_annul,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_ready,
  output logic                  stall_req
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};

  // One restoring step: shift, trial-subtract divisor from the upper half, keep if non-negative.
  function automatic logic [2*DATA_W:0] div_step(input logic [2*DATA_W:0] work,
                                                 input logic [DATA_W-1:0]  dsor);
    logic [2*DATA_W:0] sh;
    logic [DATA_W+1:0] diff;
    sh   = work << 1;
    diff = {1'b0, sh[2*DATA_W:DATA_W]} - {2'b00, dsor};
    if (!diff[DATA_W+1]) begin
      div_step = {diff[DATA_W:0], sh[DATA_W-1:1], 1'b1};
    end else begin
      div_step = sh;
    end
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag, input logic neg);
    apply_sign = neg ? (~mag + ONE_W) : mag;
  endfunction

  div_state_t          state_r, state_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic [2*DATA_W:0]   work_r, work_nxt_s, step_s;
  logic [DATA_W-1:0]   dsor_r, dsor_nxt_s;
  logic                q_neg_r, q_neg_nxt_s, r_neg_r, r_neg_nxt_s;
  logic [2*DATA_W-1:0] result_r, result_nxt_s;
  logic                ready_r, ready_nxt_s;
  logic                s1_s, s2_s;

  assign s1_s   = div_signed & div_opdata1[DATA_W-1];
  assign s2_s   = div_signed & div_opdata2[DATA_W-1];
  assign step_s = div_step(work_r, dsor_r);

  // Next-state and next-datapath decode.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    work_nxt_s   = work_r;
    dsor_nxt_s   = dsor_r;
    q_neg_nxt_s  = q_neg_r;
    r_neg_nxt_s  = r_neg_r;
    result_nxt_s = result_r;
    ready_nxt_s  = ready_r;
    case (state_r)
      IDLE: begin
        if (div_start && !div_annul) begin
          if (div_opdata2 == {DATA_W{1'b0}}) begin
            state_nxt_s = DIVZERO;
          end else begin
            state_nxt_s = BUSY;
            work_nxt_s  = {{(DATA_W+1){1'b0}}, apply_sign(div_opdata1, s1_s)};
            dsor_nxt_s  = apply_sign(div_opdata2, s2_s);
            q_neg_nxt_s = s1_s ^ s2_s;
            r_neg_nxt_s = s1_s;
            cnt_nxt_s   = {CW{1'b0}};
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIVZERO: begin
        result_nxt_s = {(2*DATA_W){1'b0}};
        if (div_annul) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      BUSY: begin
        if (div_annul) begin
          state_nxt_s = IDLE;
        end else begin
          work_nxt_s = step_s;
          cnt_nxt_s  = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s  = DONE;
            result_nxt_s = {apply_sign(step_s[2*DATA_W-1:DATA_W], r_neg_r),
                            apply_sign(step_s[DATA_W-1:0], q_neg_r)};
          end else begin
            state_nxt_s = BUSY;
          end
        end
      end
      DONE: begin
        if (!div_start) begin
          state_nxt_s  = IDLE;
          ready_nxt_s  = 1'b0;
          result_nxt_s = {(2*DATA_W){1'b0}};
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        ready_nxt_s  = 1'b0;
        result_nxt_s = {(2*DATA_W){1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      work_r   <= {(2*DATA_W+1){1'b0}};
      dsor_r   <= {DATA_W{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_r <= {(2*DATA_W){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      work_r   <= work_nxt_s;
      dsor_r   <= dsor_nxt_s;
      q_neg_r  <= q_neg_nxt_s;
      r_neg_r  <= r_neg_nxt_s;
      result_r <= result_nxt_s;
      ready_r  <= ready_nxt_s;
    end
  end

  assign div_result = result_r;
  assign div_ready  = ready_r;
  assign stall_req  = div_start & ~ready_r & ~div_annul;

endmodule

// File: doc/exe_div.md
Name: exe_div

Overview:
- Multi-cycle integer divider, the responder behind the EXE stage for DIV/DIVU.
- EXE holds operands and asserts a start request. The block runs radix-2 restoring division and returns a 64-bit {remainder, quotient} result with a ready handshake.
- It raises a stall request so the ID→EXE pipeline register and earlier stages hold until the result is available.
- Its result feeds the HI/LO write path.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- div_start  in  1  EXE requests a division; held high until div_ready is seen
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start in IDLE
- div_opdata1  in  DATA_W  dividend; sampled in IDLE
- div_opdata2  in  DATA_W  divisor; sampled in IDLE
- div_annul  in  1  cancel an in-flight division (exception/flush)
- div_result  out  2*DATA_W  [63:32] = remainder (HI), [31:0] = quotient (LO)
- div_ready  out  1  result valid
- stall_req  out  1  asks the pipeline to hold EXE and upstream stages

Behaviour:
- Reset: one clock and reset. rst is synchronous and active-high (port names clk, rst). On rst: state = IDLE, div_result = 0, div_ready = 0, counter = 0, working register = 0. rst wins over every other input, including mid-division; no ready is produced for an aborted operation.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - div_start=1 and div_annul=0 and divisor==0 → DIVZERO.
  - div_start=1 and div_annul=0 and divisor!=0 → BUSY; the block latches the operand magnitudes, operand signs and signed flag, and clears the counter.
  - Otherwise it stays in IDLE.
- Magnitudes: for signed operations, negative operands are two's-complement negated; unsigned operands are used as-is. The result signs are also latched: quotient sign = s1 XOR s2, remainder sign = s1.
- BUSY:
  - Each cycle performs one restoring step on a (2*DATA_W+1)-bit working register: shift left 1; trial-subtract the divisor from the upper half; if the result is non-negative, keep the difference and set quotient bit 0 = 1, else quotient bit 0 = 0.
  - The counter increments each cycle. After DATA_W steps (counter == DATA_W-1 on the final step) the state goes to DONE.
  - On the DONE transition the block registers the sign-fixed result into div_result.
- DIVZERO: div_result = 0 (quotient 0, remainder 0), then → DONE next cycle. This result is architecturally UNPREDICTABLE but is fixed to 0 for determinism.
- DONE:
  - div_ready = 1 and div_result is held stable.
  - If div_start = 0, the state goes to IDLE, and div_ready and div_result clear to 0 on that edge.
  - If div_start stays 1, the block remains in DONE (no re-trigger).
- Latency: start sampled at edge T → BUSY T+1 … T+DATA_W → DONE, div_ready=1 after edge T+DATA_W+1 (33 cycles for DATA_W=32). Divide-by-zero: div_ready=1 after edge T+2.
- Annul: div_annul=1 in DIVZERO or BUSY → IDLE next edge; div_ready stays 0 and div_result stays 0. div_annul in IDLE blocks a new start. div_annul in DONE is ignored (the result is already produced).
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. The unsigned magnitude 2^31 is handled by the DATA_W-bit unsigned path and needs no special case.
- stall_req is combinational: div_start & ~div_ready & ~div_annul. This keeps the ID→EXE register frozen until the result cycle.
- Operand changes while not in IDLE are ignored; only the latched copies are used.

Decomposition:
- Shared package (cpu_defs):
  - div_state_t enum {IDLE, DIVZERO, BUSY, DONE}
  - DIV_ITERS = DATA_W
  - aluop codes for DIV/DIVU, which EXE uses to decode div_start/div_signed
- No sub-module. The single restoring step is a local function inside exe_div; a separate module adds ports without reuse value.

Test Plan:
- Unsigned 7/2 (div_signed=0, start held) → div_ready exactly 33 cycles after the start edge, div_result = {0x00000001, 0x00000003}; stall_req high for the full 33 cycles, low once ready.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 0x12345678/0 → div_ready 2 cycles after start, div_result = 0; then drop start → div_ready=0 next cycle and state back to IDLE.
- Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- div_annul pulsed 10 cycles into BUSY → no div_ready ever for that op, stall_req low. A new start (100/7) next cycle → ready 33 cycles later, result {2, 14}.
- rst asserted at cycle 20 of a division → all outputs 0 next edge. A start after reset deasserts gives a correct fresh result with full latency.
